// File: rtl/linear_tile_scheduler_pkg.sv
// Shared constants and FSM encoding for the linear tile scheduler.
package linear_tile_scheduler_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned LANES      = 16;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned ROW_W      = LANES * DATA_WIDTH;

    // 1.0 in Q3.12
    localparam logic [DATA_WIDTH-1:0] ONE = 16'd4096;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StStream,
        StDrain,
        StWrite,
        StDone
    } lts_state_e;

endpackage

// File: rtl/lts_addr_gen.sv
// Issue/tile counters and x/W/bias/y address generation for the tile scheduler.
module lts_addr_gen
    import linear_tile_scheduler_pkg::*;
#(
    parameter int unsigned TILE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              next_tile,
    input  logic              issue_inc,
    input  logic [LEN_W-1:0]  cmd_in_len,
    input  logic [TILE_W-1:0] cmd_out_tiles,
    input  logic [ADDR_W-1:0] cmd_x_base,
    input  logic [ADDR_W-1:0] cmd_w_base,
    input  logic [ADDR_W-1:0] cmd_b_base,
    input  logic [ADDR_W-1:0] cmd_y_base,
    output logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] y_addr,
    output logic              issue_done,
    output logic              last_tile
);

    logic [LEN_W-1:0]  len_q;
    logic [TILE_W-1:0] out_tiles_q;
    logic [ADDR_W-1:0] x_base_q, w_base_q, b_base_q, y_base_q;
    logic [LEN_W-1:0]  issue_q;
    logic [TILE_W-1:0] tile_q;
    logic [ADDR_W-1:0] row_off_q;  // tile * in_len, built by repeated addition

    // Command latch plus issue/tile/row-offset counters
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            out_tiles_q <= '0;
            x_base_q    <= '0;
            w_base_q    <= '0;
            b_base_q    <= '0;
            y_base_q    <= '0;
            issue_q     <= '0;
            tile_q      <= '0;
            row_off_q   <= '0;
        end else if (load) begin
            len_q       <= cmd_in_len;
            out_tiles_q <= cmd_out_tiles;
            x_base_q    <= cmd_x_base;
            w_base_q    <= cmd_w_base;
            b_base_q    <= cmd_b_base;
            y_base_q    <= cmd_y_base;
            issue_q     <= '0;
            tile_q      <= '0;
            row_off_q   <= '0;
        end else if (next_tile) begin
            issue_q   <= '0;
            tile_q    <= tile_q + TILE_W'(1);
            row_off_q <= row_off_q + ADDR_W'(len_q);
        end else if (issue_inc) begin
            issue_q <= issue_q + LEN_W'(1);
        end
    end

    // Address arithmetic wraps modulo 2^ADDR_W
    always_comb begin
        len        = len_q;
        x_addr     = x_base_q + ADDR_W'(issue_q);
        w_addr     = w_base_q + row_off_q + ADDR_W'(issue_q);
        b_addr     = b_base_q + ADDR_W'(tile_q);
        y_addr     = y_base_q + ADDR_W'(tile_q);
        issue_done = (issue_q == len_q);
        last_tile  = (tile_q == out_tiles_q - TILE_W'(1));
    end

endmodule

// File: rtl/linear_tile_scheduler.sv
// Sequences the 16-lane linear engine over out_tiles output tiles of y = W*x + b.
module linear_tile_scheduler
    import linear_tile_scheduler_pkg::*;
#(
    parameter int unsigned TILE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic [LEN_W-1:0]      cmd_in_len,
    input  logic [TILE_W-1:0]     cmd_out_tiles,
    input  logic [ADDR_W-1:0]     cmd_x_base,
    input  logic [ADDR_W-1:0]     cmd_w_base,
    input  logic [ADDR_W-1:0]     cmd_b_base,
    input  logic [ADDR_W-1:0]     cmd_y_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  rd_stall,
    output logic                  x_rd_en,
    output logic [ADDR_W-1:0]     x_rd_addr,
    input  logic [DATA_WIDTH-1:0] x_rd_data,
    output logic                  w_rd_en,
    output logic [ADDR_W-1:0]     w_rd_addr,
    input  logic [ROW_W-1:0]      w_rd_data,
    output logic                  b_rd_en,
    output logic [ADDR_W-1:0]     b_rd_addr,
    input  logic [ROW_W-1:0]      b_rd_data,
    output logic                  ll_start,
    output logic                  ll_en,
    output logic [LEN_W-1:0]      ll_len,
    output logic [DATA_WIDTH-1:0] ll_x_val,
    output logic [ROW_W-1:0]      ll_w_row,
    output logic [ROW_W-1:0]      ll_bias,
    input  logic                  ll_done,
    input  logic [ROW_W-1:0]      ll_y,
    output logic                  y_wr_en,
    output logic [ADDR_W-1:0]     y_wr_addr,
    output logic [ROW_W-1:0]      y_wr_data
);

    lts_state_e        state_q, state_d;
    logic              err_q;
    logic              ll_en_q;
    logic              bias_pend_q;
    logic [ROW_W-1:0]  bias_q;
    logic [ROW_W-1:0]  y_q;

    logic              accept, cmd_zero;
    logic              rd_fire, next_tile;
    logic              issue_done, last_tile;
    logic [ADDR_W-1:0] x_addr, w_addr, b_addr, y_addr;

    assign accept   = (state_q == StIdle) && cmd_start;
    assign cmd_zero = (cmd_in_len == '0) || (cmd_out_tiles == '0);

    lts_addr_gen #(
        .TILE_W (TILE_W)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .load          (accept),
        .next_tile     (next_tile),
        .issue_inc     (rd_fire),
        .cmd_in_len    (cmd_in_len),
        .cmd_out_tiles (cmd_out_tiles),
        .cmd_x_base    (cmd_x_base),
        .cmd_w_base    (cmd_w_base),
        .cmd_b_base    (cmd_b_base),
        .cmd_y_base    (cmd_y_base),
        .len           (ll_len),
        .x_addr        (x_addr),
        .w_addr        (w_addr),
        .b_addr        (b_addr),
        .y_addr        (y_addr),
        .issue_done    (issue_done),
        .last_tile     (last_tile)
    );

    // State register and datapath registers (en delay, bias latch, result capture)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            ll_en_q     <= 1'b0;
            bias_pend_q <= 1'b0;
            bias_q      <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            ll_en_q     <= rd_fire;
            bias_pend_q <= (state_q == StStart);
            if (accept) begin
                err_q <= cmd_zero;
            end
            if (bias_pend_q) begin
                bias_q <= b_rd_data;
            end
            if (ll_done && (state_q == StStream || state_q == StDrain)) begin
                y_q <= ll_y;
            end
        end
    end

    // Next-state logic and read issue
    always_comb begin
        state_d   = state_q;
        rd_fire   = 1'b0;
        next_tile = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    state_d = cmd_zero ? StDone : StStart;
                end
            end
            StStart: begin
                rd_fire = !rd_stall;
                state_d = StStream;
            end
            StStream: begin
                if (ll_done) begin
                    state_d = StWrite;
                end else if (issue_done) begin
                    state_d = StDrain;
                end else begin
                    rd_fire = !rd_stall;
                end
            end
            StDrain: begin
                if (ll_done) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (last_tile) begin
                    state_d = StDone;
                end else begin
                    next_tile = 1'b1;
                    state_d   = StStart;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; addresses forced to zero when not strobed
    always_comb begin
        busy      = (state_q == StStart) || (state_q == StStream) ||
                    (state_q == StDrain) || (state_q == StWrite);
        done      = (state_q == StDone);
        err       = (state_q == StDone) && err_q;
        x_rd_en   = rd_fire;
        w_rd_en   = rd_fire;
        x_rd_addr = rd_fire ? x_addr : '0;
        w_rd_addr = rd_fire ? w_addr : '0;
        b_rd_en   = (state_q == StStart);
        b_rd_addr = b_rd_en ? b_addr : '0;
        ll_start  = (state_q == StStart);
        ll_en     = ll_en_q;
        ll_x_val  = x_rd_data;
        ll_w_row  = w_rd_data;
        ll_bias   = bias_q;
        y_wr_en   = (state_q == StWrite);
        y_wr_addr = y_wr_en ? y_addr : '0;
        y_wr_data = y_q;
    end

endmodule

// File: tb/tb_linear_tile_scheduler.sv
// Self-checking bench for linear_tile_scheduler with RAM and engine models.
module tb_linear_tile_scheduler;
    import linear_tile_scheduler_pkg::*;

    localparam int unsigned TILE_W = 8;

    logic                  clk, reset, cmd_start, rd_stall, ll_done;
    logic [LEN_W-1:0]      cmd_in_len;
    logic [TILE_W-1:0]     cmd_out_tiles;
    logic [ADDR_W-1:0]     cmd_x_base, cmd_w_base, cmd_b_base, cmd_y_base;
    logic                  busy, done, err;
    logic                  x_rd_en, w_rd_en, b_rd_en;
    logic [ADDR_W-1:0]     x_rd_addr, w_rd_addr, b_rd_addr, y_wr_addr;
    logic [DATA_WIDTH-1:0] x_rd_data, ll_x_val;
    logic [ROW_W-1:0]      w_rd_data, b_rd_data, ll_w_row, ll_bias, ll_y, y_wr_data;
    logic                  ll_start, ll_en, y_wr_en;
    logic [LEN_W-1:0]      ll_len;

    linear_tile_scheduler #(
        .TILE_W (TILE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_start     (cmd_start),
        .cmd_in_len    (cmd_in_len),
        .cmd_out_tiles (cmd_out_tiles),
        .cmd_x_base    (cmd_x_base),
        .cmd_w_base    (cmd_w_base),
        .cmd_b_base    (cmd_b_base),
        .cmd_y_base    (cmd_y_base),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rd_stall      (rd_stall),
        .x_rd_en       (x_rd_en),
        .x_rd_addr     (x_rd_addr),
        .x_rd_data     (x_rd_data),
        .w_rd_en       (w_rd_en),
        .w_rd_addr     (w_rd_addr),
        .w_rd_data     (w_rd_data),
        .b_rd_en       (b_rd_en),
        .b_rd_addr     (b_rd_addr),
        .b_rd_data     (b_rd_data),
        .ll_start      (ll_start),
        .ll_en         (ll_en),
        .ll_len        (ll_len),
        .ll_x_val      (ll_x_val),
        .ll_w_row      (ll_w_row),
        .ll_bias       (ll_bias),
        .ll_done       (ll_done),
        .ll_y          (ll_y),
        .y_wr_en       (y_wr_en),
        .y_wr_addr     (y_wr_addr),
        .y_wr_data     (y_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models, 1-cycle read latency
    logic [DATA_WIDTH-1:0] x_mem [logic [15:0]];
    logic [ROW_W-1:0]      w_mem [logic [15:0]];
    logic [ROW_W-1:0]      b_mem [logic [15:0]];

    always @(posedge clk) begin
        x_rd_data <= (x_rd_en && x_mem.exists(x_rd_addr)) ? x_mem[x_rd_addr] : '0;
        w_rd_data <= (w_rd_en && w_mem.exists(w_rd_addr)) ? w_mem[w_rd_addr] : '0;
        b_rd_data <= (b_rd_en && b_mem.exists(b_rd_addr)) ? b_mem[b_rd_addr] : '0;
    end

    // Engine model: Q3.12 MAC per lane, done 4 cycles after the last en
    function automatic logic [ROW_W-1:0] mac(input logic [ROW_W-1:0] acc,
                                             input logic [15:0] x, input logic [ROW_W-1:0] w);
        logic signed [31:0] p;
        logic [ROW_W-1:0]   r;
        r = acc;
        for (int j = 0; j < LANES; j++) begin
            p = $signed(x) * $signed(w[j*16 +: 16]);
            r[j*16 +: 16] = r[j*16 +: 16] + p[27:12];
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] add_rows(input logic [ROW_W-1:0] a,
                                                  input logic [ROW_W-1:0] b);
        logic [ROW_W-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*16 +: 16] = a[j*16 +: 16] + b[j*16 +: 16];
        return r;
    endfunction

    logic [ROW_W-1:0] eng_acc, eng_y;
    logic [3:0]       eng_pipe;
    int               eng_cnt;
    logic             done_force;

    always @(posedge clk) begin
        if (reset) begin
            eng_acc  <= '0;
            eng_y    <= '0;
            eng_pipe <= '0;
            eng_cnt  <= 0;
        end else begin
            if (ll_start) begin
                eng_acc <= '0;
                eng_cnt <= 0;
            end else if (ll_en) begin
                eng_acc <= mac(eng_acc, ll_x_val, ll_w_row);
                eng_cnt <= eng_cnt + 1;
            end
            eng_pipe <= {eng_pipe[2:0], ll_en && !ll_start && (eng_cnt + 1 == int'(ll_len))};
            if (eng_pipe[2]) eng_y <= add_rows(eng_acc, ll_bias);
        end
    end

    assign ll_done = eng_pipe[3] | done_force;
    assign ll_y    = eng_y;

    // Vector table
    typedef struct {
        int          in_len;
        int          out_tiles;
        logic [15:0] x_base, w_base, b_base, y_base;
        int          kind;
        logic [31:0] stall_mask;
        int          exp_done_rel;
        logic        exp_err;
        logic [7:0]  exp_en_pat;
    } vec_t;

    vec_t vecs[6];

    // Recorders
    int               n_checks, n_fail;
    int               rel, starts, en_cnt, done_rel, done_cnt;
    logic             done_seen, done_err;
    logic [7:0]       en_pat;
    logic [31:0]      stall_mask;
    logic [15:0]      w_addrs[$], x_addrs[$], b_addrs[$], wr_addrs[$];
    logic [ROW_W-1:0] wr_data[$];

    task automatic check(input string name, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        rel = -1; starts = 0; en_cnt = 0; done_rel = -1; done_cnt = 0;
        done_seen = 1'b0; done_err = 1'b0; en_pat = '0;
        w_addrs.delete(); x_addrs.delete(); b_addrs.delete();
        wr_addrs.delete(); wr_data.delete();
    endtask

    // One clock: track cycles since ll_start, drive stall, then sample outputs
    task automatic cycle();
        @(negedge clk);
        if (ll_start) begin
            rel = 0;
            starts++;
            en_pat = '0;
        end else if (rel >= 0) begin
            rel++;
        end
        rd_stall = (rel >= 0 && rel < 32) ? stall_mask[rel[4:0]] : 1'b0;
        #1;
        if (w_rd_en) w_addrs.push_back(w_rd_addr);
        if (x_rd_en) x_addrs.push_back(x_rd_addr);
        if (b_rd_en) b_addrs.push_back(b_rd_addr);
        if (ll_en) begin
            en_cnt++;
            if (rel >= 1 && rel <= 8) en_pat[3'(rel - 1)] = 1'b1;
        end
        if (y_wr_en) begin
            wr_addrs.push_back(y_wr_addr);
            wr_data.push_back(y_wr_data);
        end
        if (done) begin
            done_seen = 1'b1;
            done_rel  = rel;
            done_err  = err;
            done_cnt++;
        end
    endtask

    function automatic logic [ROW_W-1:0] w_row(input int kind, input int k);
        logic [ROW_W-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*16 +: 16] = (kind == 0) ? 16'd1024 : 16'(j + k);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] b_row(input int kind, input int t);
        logic [ROW_W-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*16 +: 16] = (kind == 0) ? 16'd512 : 16'(256 * t);
        return r;
    endfunction

    // Hand-derived tile result: kind 0 is 4*(1.0*0.25)+0.125 = 1.125; kind 1 sums j+k over the
    // tile's rows plus 256*t
    function automatic logic [ROW_W-1:0] exp_row(input int kind, input int len, input int t);
        logic [ROW_W-1:0] r;
        for (int j = 0; j < LANES; j++) begin
            if (kind == 0) r[j*16 +: 16] = 16'd4608;
            else r[j*16 +: 16] = 16'(len*j + len*len*t + len*(len-1)/2 + 256*t);
        end
        return r;
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        int   n;
        v = vecs[i];
        x_mem.delete(); w_mem.delete(); b_mem.delete();
        for (int k = 0; k < v.in_len; k++) x_mem[16'(v.x_base + k)] = ONE;
        for (int k = 0; k < v.in_len * v.out_tiles; k++) w_mem[16'(v.w_base + k)] = w_row(v.kind, k);
        for (int t = 0; t < v.out_tiles; t++) b_mem[16'(v.b_base + t)] = b_row(v.kind, t);
        clear_rec();
        stall_mask    = v.stall_mask;
        cmd_in_len    = 16'(v.in_len);
        cmd_out_tiles = 8'(v.out_tiles);
        cmd_x_base    = v.x_base;
        cmd_w_base    = v.w_base;
        cmd_b_base    = v.b_base;
        cmd_y_base    = v.y_base;
        cmd_start     = 1'b1;
        cycle();
        cmd_start = 1'b0;
        for (int c = 0; c < 600 && !done_seen; c++) cycle();
        cycle();
        cycle();
        check($sformatf("v%0d_done_seen", i), done_seen, 1'b1);
        check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
        check($sformatf("v%0d_err", i), done_err, v.exp_err);
        check($sformatf("v%0d_done_rel", i), done_rel, v.exp_done_rel);
        check($sformatf("v%0d_en_pat", i), en_pat, v.exp_en_pat);
        n = v.exp_err ? 0 : v.in_len * v.out_tiles;
        check($sformatf("v%0d_starts", i), starts, v.exp_err ? 0 : v.out_tiles);
        check($sformatf("v%0d_en_cnt", i), en_cnt, n);
        check($sformatf("v%0d_w_cnt", i), w_addrs.size(), n);
        check($sformatf("v%0d_x_cnt", i), x_addrs.size(), n);
        for (int k = 0; k < n && k < w_addrs.size() && k < x_addrs.size(); k++) begin
            check($sformatf("v%0d_w_addr%0d", i, k), w_addrs[k], 16'(v.w_base + k));
            check($sformatf("v%0d_x_addr%0d", i, k), x_addrs[k], 16'(v.x_base + k % v.in_len));
        end
        n = v.exp_err ? 0 : v.out_tiles;
        check($sformatf("v%0d_b_cnt", i), b_addrs.size(), n);
        check($sformatf("v%0d_wr_cnt", i), wr_addrs.size(), n);
        for (int t = 0; t < n && t < wr_addrs.size() && t < b_addrs.size(); t++) begin
            check($sformatf("v%0d_b_addr%0d", i, t), b_addrs[t], 16'(v.b_base + t));
            check($sformatf("v%0d_wr_addr%0d", i, t), wr_addrs[t], 16'(v.y_base + t));
            check($sformatf("v%0d_wr_data%0d", i, t), wr_data[t], exp_row(v.kind, v.in_len, t));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {busy, done, err, x_rd_en, w_rd_en, b_rd_en, ll_start, ll_en,
                               y_wr_en}, 9'd0);
        check({tag, "_addr"}, {x_rd_addr, w_rd_addr, b_rd_addr, y_wr_addr}, 64'd0);
        check({tag, "_ll_len"}, ll_len, 16'd0);
        check({tag, "_ll_bias"}, ll_bias, '0);
        check({tag, "_y_data"}, y_wr_data, '0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{4, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 32'h0, 10, 1'b0, 8'h0F};
        vecs[1] = '{3, 3, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1, 32'h0, 9, 1'b0, 8'h07};
        vecs[2] = '{4, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 32'h6, 12, 1'b0, 8'h39};
        vecs[3] = '{0, 1, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 32'h0, -1, 1'b1, 8'h00};
        vecs[4] = '{4, 0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 32'h0, -1, 1'b1, 8'h00};
        vecs[5] = '{4, 2, 16'h0500, 16'hFFFE, 16'hFFFF, 16'hFFFF, 0, 32'h0, 10, 1'b0, 8'h0F};

        reset = 1'b1; cmd_start = 1'b0; rd_stall = 1'b0; done_force = 1'b0;
        cmd_in_len = '0; cmd_out_tiles = '0;
        cmd_x_base = '0; cmd_w_base = '0; cmd_b_base = '0; cmd_y_base = '0;
        stall_mask = '0;
        clear_rec();
        cycle(); cycle(); cycle();
        check_idle_outputs("reset");
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Re-issued start while busy is ignored, then reset mid-STREAM aborts cleanly
        x_mem.delete(); w_mem.delete(); b_mem.delete();
        clear_rec();
        stall_mask = '0;
        cmd_in_len = 16'd8; cmd_out_tiles = 8'd2;
        cmd_x_base = 16'h0100; cmd_w_base = 16'h0200; cmd_b_base = 16'h0300; cmd_y_base = 16'h0400;
        cmd_start = 1'b1;
        cycle();
        cmd_start = 1'b0;
        for (int c = 0; c < 50 && rel != 3; c++) cycle();
        check("t5_reach_stream", rel, 3);
        cmd_start = 1'b1; cmd_in_len = 16'd1; cmd_out_tiles = 8'd5;
        cycle();
        cmd_start = 1'b0;
        check("t5_len_held", ll_len, 16'd8);
        check("t5_busy", busy, 1'b1);
        check("t5_reading", w_rd_en, 1'b1);
        reset = 1'b1;
        cycle();
        check_idle_outputs("t5_abort");
        reset = 1'b0;
        clear_rec();
        for (int c = 0; c < 40; c++) cycle();
        check("t5_no_write", wr_addrs.size(), 0);
        check("t5_no_done", done_cnt, 0);
        check("t5_no_start", starts, 0);
        check("t5_no_read", w_addrs.size(), 0);

        // Stray engine done while idle must not cause a write or completion
        done_force = 1'b1;
        cycle();
        done_force = 1'b0;
        cycle(); cycle(); cycle();
        check("stray_done_write", wr_addrs.size(), 0);
        check("stray_done_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/linear_tile_scheduler.md
Name: linear_tile_scheduler

Overview:
Sequences the 16-lane linear layer engine across a full matrix-vector product y = W·x + b, where OUT_DIM = 16·out_tiles.
For each 16-output tile it:
- pulses the engine start,
- streams in_len (x, W-row) pairs from on-chip RAM, gating the engine's en with RAM data validity and arbitration stalls,
- fetches the tile bias,
- writes the 16-lane result back to the output buffer.

It sits between the layer-level controller (command/done) and the linear engine plus its RAMs.

Parameters:
DATA_WIDTH, 16, element width (Q3.12 fixed point); taken from the shared package.
LANES, 16, outputs per tile; must match the engine.
ADDR_W, 16, RAM address width.
TILE_W, 8, width of the tile counter / out_tiles.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_start  in  1  start pulse; accepted only in IDLE
cmd_in_len  in  16  elements per dot product
cmd_out_tiles  in  TILE_W  number of 16-output tiles
cmd_x_base, cmd_w_base, cmd_b_base, cmd_y_base  in  ADDR_W each  base addresses
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when cmd_in_len==0 or cmd_out_tiles==0
rd_stall  in  1  RAM arbitration stall; no x/W read issued this cycle
x_rd_en, x_rd_addr  out  1, ADDR_W  x RAM read (1-cycle latency)
x_rd_data  in  DATA_WIDTH
w_rd_en, w_rd_addr  out  1, ADDR_W  W RAM read; one row of LANES weights per address
w_rd_data  in  LANES*DATA_WIDTH
b_rd_en, b_rd_addr  out  1, ADDR_W  bias RAM read; one tile of biases per address
b_rd_data  in  LANES*DATA_WIDTH
ll_start, ll_en  out  1 each  engine control
ll_len  out  16  registered copy of cmd_in_len
ll_x_val  out  DATA_WIDTH  equals x_rd_data
ll_w_row  out  LANES*DATA_WIDTH  equals w_rd_data
ll_bias  out  LANES*DATA_WIDTH  latched bias register
ll_done  in  1  engine done, one-cycle pulse
ll_y  in  LANES*DATA_WIDTH  engine result
y_wr_en, y_wr_addr, y_wr_data  out  1, ADDR_W, LANES*DATA_WIDTH  output buffer write

Behaviour:
Reset (synchronous): state IDLE; all counters cleared; every output 0, including the ll_bias register and y_wr_data.

Command acceptance:
- In IDLE, cmd_start latches all cmd_* fields; busy rises the next cycle.
- cmd_start is ignored while busy.

State machine:
- IDLE: on cmd_start with a zero length or zero tile count, go to DONE with err set. Otherwise go to START with tile=0.
- START (1 cycle): ll_start=1; b_rd_en=1 with b_rd_addr = b_base+tile; issue = 0. Also issue the first x/W read if !rd_stall.
- STREAM: each cycle with !rd_stall and issue<in_len:
  - x_rd_en = w_rd_en = 1
  - x_rd_addr = x_base+issue
  - w_rd_addr = w_base + tile·in_len + issue (16-bit wrap)
  - issue increments
- Leave STREAM for DRAIN once issue==in_len.
- ll_en is x_rd_en delayed one cycle, so exactly in_len ll_en cycles occur per tile. Stall cycles produce ll_en=0 bubbles.
- ll_bias latches b_rd_data in the cycle after START and holds it for the whole tile.
- DRAIN: wait for ll_done. While waiting, ll_start=0 and no reads are issued.
- On ll_done (any state from STREAM onward), capture ll_y into y_wr_data and go to WRITE.
- WRITE (1 cycle): y_wr_en=1, y_wr_addr = y_base+tile. If tile==out_tiles-1 go to DONE; else tile+1 and go to START.
- DONE (1 cycle): done=1; busy falls; return to IDLE.

Latency:
- Per tile, with no stalls: 1 (START) + in_len (STREAM) + engine tail of 4 cycles to ll_done + 1 (WRITE).
- With no stalls and in_len≥1, ll_done arrives exactly in_len+4 cycles after the ll_start cycle.
- Each stall cycle adds one cycle.

Boundary cases:
- rd_stall in the START cycle delays the first read only; ll_start is still a single pulse.
- An ll_done seen outside DRAIN/STREAM is ignored.
- Reset mid-operation aborts to IDLE with no write and no done pulse.
- Address arithmetic is modulo 2^ADDR_W.

Decomposition:
Shared package: DATA_WIDTH, LANES, ADDR_W, the Q3.12 ONE constant (4096), and the state encodings.
One sub-module is natural: lts_addr_gen, which holds the issue/tile counters and the x/W/b/y address computation including the tile·in_len row-offset accumulator. The row offset is built incrementally (add in_len per tile, no multiplier).

Test Plan:
1. in_len=4, out_tiles=1, x=[4096]*4, W rows all lanes=1024, b=512 → single y write at y_base, every lane = 4608; done pulse 10 cycles after the START cycle.
2. in_len=3, out_tiles=3, W lane j of row k = j+k → three writes at y_base..y_base+2 with the correct per-tile sums; W addresses w_base+{0..2}, {3..5}, {6..8}.
3. rd_stall high on issues 1 and 2 of in_len=4 → ll_en pattern 1,0,0,1,1,1; same results as with no stalls; completion 2 cycles later.
4. cmd_in_len=0 → done and err on the same cycle; no ll_start, no reads, no writes.
5. cmd_start re-pulsed while busy → ignored; reset asserted mid-STREAM → next cycle all outputs 0, state IDLE, no y write.
6. w_base=0xFFFE, in_len=4 → w_rd_addr sequence FFFE, FFFF, 0000, 0001.
